ram_mfc_responder: RTL and testbench

//  Memory-side responder for the control unit's RAM handshake. The control unit issues RAM_enable with
//  RAM_OpCode, address and store data. This block captures the request, waits a programmable access

---
 rtl/ram_mfc_responder.sv | 168 ++++++++++++++++
 tb/tb_ram_mfc_responder.sv | 200 ++++++++++++++++++++
 2 files changed

// File: rtl/ram_mfc_responder.sv
// RAM-side responder for the control unit's RAM_enable/MFC handshake: captures a request, waits LATENCY
// cycles, then does a big-endian byte/half/word access. Optional trap on misalignment: MISALIGN_TRAP_EN.
module ram_mfc_responder #(
  parameter int ADDR_W  = 9,
  parameter int LATENCY = 2
) (
  input  logic              Clk,
  input  logic              RESET,
  input  logic              RAM_enable,
  input  logic [5:0]        RAM_OpCode,
  input  logic [ADDR_W-1:0] address,
  input  logic [31:0]       DataIn,
  output logic [31:0]       DataOut,
  output logic              MFC,
  output logic              MAE
);

  typedef enum logic [1:0] {S_IDLE, S_BUSY, S_DONE} state_e;
  typedef enum logic [1:0] {SZ_NONE, SZ_B, SZ_H, SZ_W} size_e;

  state_e            state_q, state_d;
  logic [3:0]        cnt_q, cnt_d;
  logic [5:0]        op_q;
  logic [ADDR_W-1:0] addr_q;
  logic [31:0]       din_q;
  logic [31:0]       dout_q;
  logic              mae_q;
  logic [7:0]        mem_q [2**ADDR_W];

  size_e             size;
  logic              is_load, is_signed, is_store;
  logic              misalign;
  logic [ADDR_W-1:0] a0, a1, a2, a3;
  logic [7:0]        b0, b1, b2, b3;
  logic [31:0]       load_val;
  logic              exec, mem_we;

  // NOTE: every signal written in always_comb gets a default first, so no path can infer a latch.
  always_comb begin
    size      = SZ_NONE;
    is_load   = 1'b0;
    is_signed = 1'b0;
    case (op_q)
      6'b000000: begin size = SZ_W; is_load = 1'b1; end
      6'b000001: begin size = SZ_B; is_load = 1'b1; end
      6'b000010: begin size = SZ_H; is_load = 1'b1; end
      6'b000100: size = SZ_W;
      6'b000101: size = SZ_B;
      6'b000110: size = SZ_H;
      6'b001001: begin size = SZ_B; is_load = 1'b1; is_signed = 1'b1; end
      6'b001010: begin size = SZ_H; is_load = 1'b1; is_signed = 1'b1; end
      default:   size = SZ_NONE;
    endcase
  end

  assign is_store = (size != SZ_NONE) && !is_load;

  always_comb begin
    a0       = addr_q;
    misalign = 1'b0;
`ifdef MISALIGN_TRAP_EN
    misalign = ((size == SZ_H) && addr_q[0]) || ((size == SZ_W) && (addr_q[1:0] != 2'b00));
`else
    if (size == SZ_H) a0 = {addr_q[ADDR_W-1:1], 1'b0};
    if (size == SZ_W) a0 = {addr_q[ADDR_W-1:2], 2'b00};
`endif
  end

  // Byte lanes wrap naturally at 2**ADDR_W through the fixed-width add.
  assign a1 = a0 + ADDR_W'(1);
  assign a2 = a0 + ADDR_W'(2);
  assign a3 = a0 + ADDR_W'(3);
  assign b0 = mem_q[a0];
  assign b1 = mem_q[a1];
  assign b2 = mem_q[a2];
  assign b3 = mem_q[a3];

  always_comb begin
    load_val = 32'd0;
    case (size)
      SZ_B:    load_val = {{24{is_signed & b0[7]}}, b0};
      SZ_H:    load_val = {{16{is_signed & b0[7]}}, b0, b1};
      SZ_W:    load_val = {b0, b1, b2, b3};
      default: load_val = 32'd0;
    endcase
  end

  assign exec   = (state_q == S_BUSY) && (cnt_q == 4'(LATENCY));
  assign mem_we = exec && is_store && !misalign;

  // NOTE: sequential state uses non-blocking assignments only.
  always_ff @(posedge Clk or negedge RESET) begin
    if (!RESET) begin
      state_q <= S_IDLE;
      cnt_q   <= 4'd0;
    end else begin
      state_q <= state_d;
      cnt_q   <= cnt_d;
    end
  end

  always_comb begin
    state_d = state_q;
    cnt_d   = cnt_q;
    case (state_q)
      S_IDLE: if (RAM_enable) begin
        state_d = S_BUSY;
        cnt_d   = 4'd0;
      end
      S_BUSY: if (exec) state_d = S_DONE;
              else      cnt_d   = cnt_q + 4'd1;
      S_DONE: if (!RAM_enable) begin
        state_d = S_IDLE;
        cnt_d   = 4'd0;
      end
      default: state_d = S_IDLE;
    endcase
  end

  always_comb begin
    MFC     = (state_q == S_DONE);
    MAE     = mae_q;
    DataOut = dout_q;
  end

  always_ff @(posedge Clk or negedge RESET) begin
    if (!RESET) begin
      op_q   <= 6'd0;
      addr_q <= '0;
      din_q  <= 32'd0;
      dout_q <= 32'd0;
      mae_q  <= 1'b0;
    end else begin
      if (state_q == S_IDLE && RAM_enable) begin
        op_q   <= RAM_OpCode;
        addr_q <= address;
        din_q  <= DataIn;
      end
      if (exec) begin
        mae_q <= misalign;
        if (misalign || size == SZ_NONE) dout_q <= 32'd0;
        else if (is_load)                dout_q <= load_val;
      end
      if (state_q == S_DONE && !RAM_enable) mae_q <= 1'b0;
    end
  end

  // NOTE: storage has no reset; contents survive RESET, and committed stores persist.
  always_ff @(posedge Clk) begin
    if (mem_we) begin
      case (size)
        SZ_B: mem_q[a0] <= din_q[7:0];
        SZ_H: begin
          mem_q[a0] <= din_q[15:8];
          mem_q[a1] <= din_q[7:0];
        end
        SZ_W: begin
          mem_q[a0] <= din_q[31:24];
          mem_q[a1] <= din_q[23:16];
          mem_q[a2] <= din_q[15:8];
          mem_q[a3] <= din_q[7:0];
        end
        default: ;
      endcase
    end
  end

endmodule

// File: tb/tb_ram_mfc_responder.sv
// Directed self-checking bench for ram_mfc_responder (ADDR_W=9, LATENCY=2).
module tb_ram_mfc_responder;

  localparam int ADDR_W  = 9;
  localparam int LATENCY = 2;

  localparam logic [5:0] OP_LD   = 6'b000000;
  localparam logic [5:0] OP_LDUB = 6'b000001;
  localparam logic [5:0] OP_LDUH = 6'b000010;
  localparam logic [5:0] OP_ST   = 6'b000100;
  localparam logic [5:0] OP_STB  = 6'b000101;
  localparam logic [5:0] OP_LDSB = 6'b001001;
  localparam logic [5:0] OP_LDSH = 6'b001010;
  localparam logic [5:0] OP_BAD  = 6'b111111;

  logic              clk;
  logic              rst_n;
  logic              ram_enable;
  logic [5:0]        ram_opcode;
  logic [ADDR_W-1:0] addr;
  logic [31:0]       data_in;
  logic [31:0]       data_out;
  logic              mfc;
  logic              mae;

  int n_checks = 0;
  int n_pass   = 0;

  logic [31:0] last_dout;
  logic        last_mae;
  int          last_edges;

  ram_mfc_responder #(.ADDR_W(ADDR_W), .LATENCY(LATENCY)) dut (
    .Clk        (clk),
    .RESET      (rst_n),
    .RAM_enable (ram_enable),
    .RAM_OpCode (ram_opcode),
    .address    (addr),
    .DataIn     (data_in),
    .DataOut    (data_out),
    .MFC        (mfc),
    .MAE        (mae)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_checks++;
    if (got === exp) n_pass++;
    else $display("FAIL %s: got 0x%08h expected 0x%08h", tag, got, exp);
  endtask

  // One full handshake from IDLE; inputs are scrambled after acceptance to prove they were captured.
  task automatic txn(input string tag, input logic [5:0] op, input logic [ADDR_W-1:0] a,
                     input logic [31:0] d);
    @(negedge clk);
    ram_enable = 1'b1;
    ram_opcode = op;
    addr       = a;
    data_in    = d;
    @(posedge clk);
    #1;
    ram_opcode = ~op;
    addr       = ~a;
    data_in    = ~d;
    last_edges = 0;
    while (!mfc && last_edges < 50) begin
      @(posedge clk);
      #1;
      last_edges++;
    end
    last_dout = data_out;
    last_mae  = mae;
    check({tag, "_lat"}, last_edges, LATENCY + 1);
    @(negedge clk);
    ram_enable = 1'b0;
    @(posedge clk);
    #1;
    check({tag, "_mfc_drop"}, {31'd0, mfc}, 32'd0);
  endtask

  initial begin
    int pulses;
    logic [31:0] held;
    rst_n      = 1'b0;
    ram_enable = 1'b0;
    ram_opcode = 6'd0;
    addr       = '0;
    data_in    = 32'd0;
    #12;
    check("rst_mfc",  {31'd0, mfc}, 32'd0);
    check("rst_mae",  {31'd0, mae}, 32'd0);
    check("rst_dout", data_out, 32'd0);
    @(negedge clk);
    rst_n = 1'b1;

    // Reset in the middle of a store: the pending store is lost.
    txn("st_base", OP_ST, 9'h020, 32'h11223344);
    txn("ld_base", OP_LD, 9'h020, 32'h0);
    check("ld_base_val", last_dout, 32'h11223344);
    @(negedge clk);
    ram_enable = 1'b1;
    ram_opcode = OP_ST;
    addr       = 9'h020;
    data_in    = 32'h55667788;
    @(posedge clk);
    @(posedge clk);
    #3;
    rst_n = 1'b0;
    #1;
    check("midrst_mfc",  {31'd0, mfc}, 32'd0);
    check("midrst_dout", data_out, 32'd0);
    @(negedge clk);
    ram_enable = 1'b0;
    rst_n      = 1'b1;
    txn("ld_after_rst", OP_LD, 9'h020, 32'h0);
    check("ld_after_rst_val", last_dout, 32'h11223344);

    // Big-endian sub-word loads.
    txn("st_dead", OP_ST, 9'h010, 32'hDEADBEEF);
    check("st_keeps_dout", last_dout, 32'h11223344);
    txn("ldub", OP_LDUB, 9'h010, 32'h0);
    check("ldub_val", last_dout, 32'h000000DE);
    txn("ldsb", OP_LDSB, 9'h013, 32'h0);
    check("ldsb_val", last_dout, 32'hFFFFFFEF);
    txn("lduh", OP_LDUH, 9'h012, 32'h0);
    check("lduh_val", last_dout, 32'h0000BEEF);
    txn("ldsh", OP_LDSH, 9'h010, 32'h0);
    check("ldsh_val", last_dout, 32'hFFFFDEAD);

    txn("stb", OP_STB, 9'h011, 32'h12345677);
    txn("ld_merge", OP_LD, 9'h010, 32'h0);
    check("ld_merge_val", last_dout, 32'hDE77BEEF);

    // Hold RAM_enable after MFC: MFC and DataOut must stay put.
    @(negedge clk);
    ram_enable = 1'b1;
    ram_opcode = OP_LDUH;
    addr       = 9'h010;
    @(posedge clk);
    for (int i = 0; i < LATENCY + 1; i++) @(posedge clk);
    #1;
    check("hold_rise", {31'd0, mfc}, 32'd1);
    held = 32'h0000DE77;
    for (int i = 0; i < 5; i++) begin
      @(posedge clk);
      #1;
      check("hold_mfc", {31'd0, mfc}, 32'd1);
      check("hold_dout", data_out, held);
    end
    @(negedge clk);
    ram_enable = 1'b0;
    @(posedge clk);
    #1;
    check("hold_drop_mfc", {31'd0, mfc}, 32'd0);
    check("hold_drop_dout", data_out, held);

    // RAM_enable dropped during BUSY: MFC still pulses for exactly one cycle.
    @(negedge clk);
    ram_enable = 1'b1;
    ram_opcode = OP_LD;
    addr       = 9'h010;
    @(posedge clk);
    @(negedge clk);
    ram_enable = 1'b0;
    pulses = 0;
    for (int i = 0; i < 10; i++) begin
      @(posedge clk);
      #1;
      if (mfc) pulses++;
    end
    check("busy_drop_pulses", pulses, 1);
    check("busy_drop_dout", data_out, 32'hDE77BEEF);

    // Misaligned word load.
    txn("ld_mis", OP_LD, 9'h013, 32'h0);
`ifdef MISALIGN_TRAP_EN
    check("ld_mis_val", last_dout, 32'h0);
    check("ld_mis_mae", {31'd0, last_mae}, 32'd1);
`else
    check("ld_mis_val", last_dout, 32'hDE77BEEF);
    check("ld_mis_mae", {31'd0, last_mae}, 32'd0);
`endif
    check("mae_drop", {31'd0, mae}, 32'd0);

    // Top of the address space and an undefined opcode.
    txn("st_top", OP_ST, 9'h1FC, 32'hA1B2C3D4);
    txn("ld_top", OP_LD, 9'h1FC, 32'h0);
    check("ld_top_val", last_dout, 32'hA1B2C3D4);
    txn("bad_op", OP_BAD, 9'h1FC, 32'h0);
    check("bad_op_dout", last_dout, 32'h0);
    txn("ld_top2", OP_LD, 9'h1FC, 32'h0);
    check("ld_top2_val", last_dout, 32'hA1B2C3D4);

    $display("%0d/%0d checks passed", n_pass, n_checks);
    $finish;
  end

endmodule
